// File: rtl/v_uesprit_doa.sv
// v_uesprit_doa: picks the dominant eigenvector and runs an iterative vectoring CORDIC to give atan2(y, x).
// Build macro DOA_MAG_OUT_EN adds a gain-corrected magnitude output and one extra pipeline cycle.
module v_uesprit_doa #(
    parameter int DIN_WIDTH  = 16,
    parameter int DIN_POINT  = 13,
    parameter int ITERS      = 14,
    parameter int DOUT_WIDTH = 16,
    parameter int DOUT_POINT = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIN_WIDTH-1:0]  lamb1,
    input  logic [DIN_WIDTH-1:0]  lamb2,
    input  logic [DIN_WIDTH-1:0]  eigen1_y,
    input  logic [DIN_WIDTH-1:0]  eigen2_y,
    input  logic [DIN_WIDTH-1:0]  eigen_x,
    input  logic                  din_valid,
    output logic [DOUT_WIDTH-1:0] angle,
    output logic [DIN_WIDTH-1:0]  lamb_max,
    output logic [DIN_WIDTH-1:0]  lamb_min,
    output logic                  sel,
    output logic                  zero_vec,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  din_drop
`ifdef DOA_MAG_OUT_EN
    ,
    output logic [DIN_WIDTH-1:0]  mag
`endif
);
    localparam int XW  = DIN_WIDTH + 2;
    localparam int ZW  = DOUT_WIDTH + 1;
    localparam int QSH = 30 - DOUT_POINT;
    localparam logic [4:0] LAST_IT = 5'(ITERS - 1);
    localparam logic [63:0] PI_Q30 = 64'd3373259426;
    localparam logic signed [ZW-1:0] PI_Z = ZW'((PI_Q30 + (64'd1 << (QSH - 1))) >> QSH);

    if (ITERS < 8 || ITERS > 16 || DIN_POINT >= DIN_WIDTH || DOUT_WIDTH - DOUT_POINT < 3) begin : g_param_check
        $error("v_uesprit_doa: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_ITER = 3'd2,
        S_MUL  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // atan(2^-i) held with 30 fraction bits, rounded to the angle's fraction width on use
    function automatic logic [ZW-1:0] atan_q(input logic [4:0] i);
        logic [31:0] c;
        case (i)
            5'd0:    c = 32'd843314857;
            5'd1:    c = 32'd497837830;
            5'd2:    c = 32'd263043837;
            5'd3:    c = 32'd133525159;
            5'd4:    c = 32'd67021687;
            5'd5:    c = 32'd33543516;
            5'd6:    c = 32'd16775851;
            5'd7:    c = 32'd8388438;
            5'd8:    c = 32'd4194283;
            5'd9:    c = 32'd2097149;
            5'd10:   c = 32'd1048576;
            5'd11:   c = 32'd524288;
            5'd12:   c = 32'd262144;
            5'd13:   c = 32'd131072;
            5'd14:   c = 32'd65536;
            5'd15:   c = 32'd32768;
            default: c = 32'd0;
        endcase
        return ZW'((c + (32'd1 << (QSH - 1))) >> QSH);
    endfunction

    function automatic logic [DOUT_WIDTH-1:0] sat_angle(input logic signed [ZW-1:0] z);
        logic [DOUT_WIDTH-1:0] r;
        if (z[ZW-1] != z[ZW-2]) begin
            r = z[ZW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}} : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end else begin
            r = z[DOUT_WIDTH-1:0];
        end
        return r;
    endfunction

    state_t state_r, state_nx_s;
    logic [4:0] iter_r;
    logic signed [XW-1:0] x_r, y_r, xsh_s, ysh_s, x_nx_s, y_nx_s;
    logic signed [ZW-1:0] z_r, z_nx_s, at_s, fin_z_s;
    logic [DIN_WIDTH-1:0] lmax_r, lmin_r, y_in_s;
    logic sel_r, zero_r, sel_in_s;
    logic accept_s, drop_s, fin_s, last_s, busy_nx_s, d_s;

    assign sel_in_s = ($signed(lamb1) < $signed(lamb2));
    assign y_in_s   = sel_in_s ? eigen2_y : eigen1_y;
    assign last_s   = (iter_r == LAST_IT);

    // Next-state and control strobes
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        drop_s     = 1'b0;
        fin_s      = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (din_valid) begin
                    accept_s   = 1'b1;
                    state_nx_s = S_PRE;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_PRE: begin
                drop_s     = din_valid;
                state_nx_s = S_ITER;
            end
            S_ITER: begin
                drop_s = din_valid;
                if (last_s) begin
`ifdef DOA_MAG_OUT_EN
                    state_nx_s = S_MUL;
`else
                    state_nx_s = S_DONE;
                    fin_s      = 1'b1;
`endif
                end else begin
                    state_nx_s = S_ITER;
                end
            end
            S_MUL: begin
                drop_s     = din_valid;
                fin_s      = 1'b1;
                state_nx_s = S_DONE;
            end
            default: state_nx_s = S_IDLE;
        endcase
        busy_nx_s = (state_nx_s == S_PRE) || (state_nx_s == S_ITER) || (state_nx_s == S_MUL);
    end

    // One CORDIC vectoring micro-rotation driving y toward zero
    always_comb begin
        d_s   = y_r[XW-1];
        xsh_s = x_r >>> iter_r;
        ysh_s = y_r >>> iter_r;
        at_s  = $signed(atan_q(iter_r));
        if (d_s) begin
            x_nx_s = x_r - ysh_s;
            y_nx_s = y_r + xsh_s;
            z_nx_s = z_r - at_s;
        end else begin
            x_nx_s = x_r + ysh_s;
            y_nx_s = y_r - xsh_s;
            z_nx_s = z_r + at_s;
        end
    end

`ifdef DOA_MAG_OUT_EN
    assign fin_z_s = z_r;
`else
    assign fin_z_s = z_nx_s;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath: latch on accept, half-plane fold in PRE, rotate in ITER
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            iter_r <= 5'd0;
            lmax_r <= '0;
            lmin_r <= '0;
            sel_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (accept_s) begin
            x_r    <= {{2{eigen_x[DIN_WIDTH-1]}}, eigen_x};
            y_r    <= {{2{y_in_s[DIN_WIDTH-1]}}, y_in_s};
            z_r    <= '0;
            iter_r <= 5'd0;
            lmax_r <= sel_in_s ? lamb2 : lamb1;
            lmin_r <= sel_in_s ? lamb1 : lamb2;
            sel_r  <= sel_in_s;
            zero_r <= (eigen_x == '0) && (y_in_s == '0);
        end else if (state_r == S_PRE) begin
            iter_r <= 5'd0;
            if (x_r[XW-1]) begin
                // z picks +pi/-pi from the original y sign so the result lands in the right half-plane
                x_r <= -x_r;
                y_r <= -y_r;
                z_r <= y_r[XW-1] ? -PI_Z : PI_Z;
            end else begin
                z_r <= '0;
            end
        end else if (state_r == S_ITER) begin
            x_r    <= x_nx_s;
            y_r    <= y_nx_s;
            z_r    <= z_nx_s;
            iter_r <= iter_r + 5'd1;
        end
    end

    // Registered result and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            angle      <= '0;
            lamb_max   <= '0;
            lamb_min   <= '0;
            sel        <= 1'b0;
            zero_vec   <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            din_drop   <= 1'b0;
        end else begin
            dout_valid <= fin_s;
            busy       <= busy_nx_s;
            din_drop   <= drop_s;
            if (fin_s) begin
                angle    <= zero_r ? '0 : sat_angle(fin_z_s);
                lamb_max <= lmax_r;
                lamb_min <= lmin_r;
                sel      <= sel_r;
                zero_vec <= zero_r;
            end
        end
    end

`ifdef DOA_MAG_OUT_EN
    localparam logic [16:0] INV_GAIN = 17'd39797;  // 0.60725 in Q16
    localparam logic signed [XW+17:0] MAG_MAX = (XW+18)'((64'd1 << (DIN_WIDTH - 1)) - 64'd1);
    logic signed [XW+17:0] mag_prod_s, mag_rnd_s;

    // Remove the CORDIC gain from the final x
    always_comb begin
        mag_prod_s = x_r * $signed({1'b0, INV_GAIN});
        mag_rnd_s  = (mag_prod_s + $signed({{(XW+2){1'b0}}, 16'h8000})) >>> 16;
    end

    // Registered magnitude, updated with the angle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag <= '0;
        end else if (fin_s) begin
            if (mag_rnd_s > MAG_MAX) begin
                mag <= MAG_MAX[DIN_WIDTH-1:0];
            end else begin
                mag <= mag_rnd_s[DIN_WIDTH-1:0];
            end
        end
    end
`endif
endmodule

// File: tb/tb_v_uesprit_doa.sv
// Bench for v_uesprit_doa: directed corner cases plus random vectors checked against a real-valued atan2 model.
module tb_v_uesprit_doa;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] lamb1, lamb2, eigen1_y, eigen2_y, eigen_x;
    logic          din_valid;
    logic [DW-1:0] angle, lamb_max, lamb_min;
    logic          sel, zero_vec, dout_valid, busy, din_drop;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    v_uesprit_doa dut (
        .clk(clk), .rst_n(rst_n),
        .lamb1(lamb1), .lamb2(lamb2),
        .eigen1_y(eigen1_y), .eigen2_y(eigen2_y), .eigen_x(eigen_x),
        .din_valid(din_valid),
        .angle(angle), .lamb_max(lamb_max), .lamb_min(lamb_min),
        .sel(sel), .zero_vec(zero_vec), .dout_valid(dout_valid),
        .busy(busy), .din_drop(din_drop)
    );

    function automatic int ref_angle(input int x, input int y);
        real a;
        if (x == 0 && y == 0) return 0;
        a = $atan2(real'(y), real'(x)) * 8192.0;
        return $rtoi(a + ((a < 0.0) ? -0.5 : 0.5));
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
        n_chk++;
        assert ((obs >= exp - tol && obs <= exp + tol) === 1'b1) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic drive(input int x, input int y1, input int y2, input int l1, input int l2);
        eigen_x   = x[DW-1:0];
        eigen1_y  = y1[DW-1:0];
        eigen2_y  = y2[DW-1:0];
        lamb1     = l1[DW-1:0];
        lamb2     = l2[DW-1:0];
        din_valid = 1'b1;
    endtask

    // Called on the negedge where din_valid was raised (cycle 0); returns the cycle dout_valid was seen
    task automatic run(output int lat);
        @(negedge clk);
        din_valid = 1'b0;
        lat = 1;
        while (dout_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int x, input int y1, input int y2,
                                input int l1, input int l2, input int tol, input int lat);
        int s, ys;
        s  = (l1 < l2) ? 1 : 0;
        ys = (s == 1) ? y2 : y1;
        chk({tag, "_latency"}, lat, 16);
        chk_near({tag, "_angle"}, int'($signed(angle)), ref_angle(x, ys), tol);
        chk({tag, "_sel"}, int'(sel), s);
        chk({tag, "_lamb_max"}, int'($signed(lamb_max)), (s == 1) ? l2 : l1);
        chk({tag, "_lamb_min"}, int'($signed(lamb_min)), (s == 1) ? l1 : l2);
        chk({tag, "_zero_vec"}, int'(zero_vec), (x == 0 && ys == 0) ? 1 : 0);
    endtask

    initial begin
        int lat, cnt, x, y1, y2, l1, l2, ys;
        rst_n = 1'b0;
        din_valid = 1'b0;
        eigen_x = '0; eigen1_y = '0; eigen2_y = '0; lamb1 = '0; lamb2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_angle", int'(angle), 0);
        chk("rst_lamb_max", int'(lamb_max), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_zero_vec", int'(zero_vec), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_din_drop", int'(din_drop), 0);
        rst_n = 1'b1;
        @(negedge clk);

        drive(4096, 4096, -777, 300, 100); run(lat);
        check_result("pi4", 4096, 4096, -777, 300, 100, 2, lat);

        drive(-4096, 0, 1111, 5, 5); run(lat);
        check_result("pi", -4096, 0, 1111, 5, 5, 2, lat);

        drive(-4096, -1, 0, 9, 2); run(lat);
        check_result("neg_pi", -4096, -1, 0, 9, 2, 4, lat);

        drive(0, 1234, -4096, 100, 200); run(lat);
        check_result("neg_pi2", 0, 1234, -4096, 100, 200, 2, lat);

        drive(-32768, -32768, 0, 1, 0); run(lat);
        check_result("fullscale", -32768, -32768, 0, 1, 0, 4, lat);

        // A second strobe mid-run is dropped and leaves the first result intact
        drive(4096, 4096, 0, 10, 5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) din_valid = 1'b0;
        end
        chk("drop_busy", int'(busy), 1);
        drive(-4096, -4096, 4096, 1, 50);
        @(negedge clk);
        din_valid = 1'b0;
        chk("drop_pulse", int'(din_drop), 1);
        @(negedge clk);
        chk("drop_pulse_end", int'(din_drop), 0);
        lat = 7;
        while (dout_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_result("drop", 4096, 4096, 0, 10, 5, 2, lat);
        chk("done_busy", int'(busy), 0);
        cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (dout_valid === 1'b1) cnt++;
        end
        chk("drop_single_valid", cnt, 0);

        // Zero vector, then a strobe on the DONE cycle is taken back-to-back
        drive(0, 0, 999, 7, 3); run(lat);
        check_result("zero", 0, 0, 999, 7, 3, 0, lat);
        drive(0, 4096, -5, 3, 3); run(lat);
        check_result("b2b_pi2", 0, 4096, -5, 3, 3, 4, lat);

        for (int i = 0; i < 10; i++) begin
            x = 0; y1 = 0; y2 = 0; l1 = 0; l2 = 0;
            for (int t = 0; t < 100; t++) begin
                x  = int'($urandom_range(0, 65535)) - 32768;
                y1 = int'($urandom_range(0, 65535)) - 32768;
                y2 = int'($urandom_range(0, 65535)) - 32768;
                l1 = int'($urandom_range(0, 65535)) - 32768;
                l2 = (i % 4 == 0) ? l1 : int'($urandom_range(0, 65535)) - 32768;
                ys = (l1 < l2) ? y2 : y1;
                if ((x >= 16384 || x <= -16384) || (ys >= 16384 || ys <= -16384)) break;
            end
            drive(x, y1, y2, l1, l2); run(lat);
            check_result("rand", x, y1, y2, l1, l2, 4, lat);
        end

        // Reset in the middle of a run aborts it silently
        drive(4096, 4096, 0, 2, 1);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_angle", int'(angle), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_lamb_max", int'(lamb_max), 0);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (dout_valid === 1'b1) cnt++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (dout_valid === 1'b1) cnt++;
        end
        chk("abort_no_valid", cnt, 0);
        drive(-4096, 4096, 0, 4, 4); run(lat);
        check_result("after_abort", -4096, 4096, 0, 4, 4, 4, lat);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
